// File: rtl/ee357_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode, execute, memory and write-back.
// Optional feature: define EE357_CTRL_ADDI_EN to add the addi path (ADDIEX -> ADDIWB).
module ee357_multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef EE357_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_t state_q;
    state_t state_d;

    // Decoded control bundle before the reset force is applied.
    logic       pc_write_d;
    logic       pc_write_cond_d;
    logic       i_or_d_d;
    logic       mem_read_d;
    logic       mem_write_d;
    logic       ir_write_d;
    logic       mem_to_reg_d;
    logic [1:0] pc_source_d;
    logic [1:0] alu_op_d;
    logic       alu_src_a_d;
    logic [1:0] alu_src_b_d;
    logic       reg_write_d;
    logic       reg_dst_d;
    logic       illegal_op_d;
    logic       opcode_legal;

    always_comb begin
        case (opcode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: opcode_legal = 1'b1;
`ifdef EE357_CTRL_ADDI_EN
            OP_ADDI:                              opcode_legal = 1'b1;
`endif
            default:                              opcode_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef EE357_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            // IR still holds the instruction, so the opcode is stable here.
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef EE357_CTRL_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        pc_write_d      = 1'b0;
        pc_write_cond_d = 1'b0;
        i_or_d_d        = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        ir_write_d      = 1'b0;
        mem_to_reg_d    = 1'b0;
        pc_source_d     = 2'b00;
        alu_op_d        = 2'b00;
        alu_src_a_d     = 1'b0;
        alu_src_b_d     = 2'b00;
        reg_write_d     = 1'b0;
        reg_dst_d       = 1'b0;
        illegal_op_d    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read_d  = 1'b1;
                alu_src_b_d = 2'b01;
                ir_write_d  = mem_ready;
                pc_write_d  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b_d  = 2'b11;
                illegal_op_d = ~opcode_legal;
            end
            S_MEMADR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_MEMRD: begin
                mem_read_d = 1'b1;
                i_or_d_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
            end
            S_MEMWR: begin
                mem_write_d = 1'b1;
                i_or_d_d    = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 2'b10;
            end
            S_ALUWB: begin
                reg_write_d = 1'b1;
                reg_dst_d   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_d     = 1'b1;
                alu_op_d        = 2'b01;
                pc_write_cond_d = 1'b1;
                pc_source_d     = 2'b01;
            end
            S_JUMP: begin
                pc_write_d  = 1'b1;
                pc_source_d = 2'b10;
            end
`ifdef EE357_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_ADDIWB: begin
                reg_write_d = 1'b1;
            end
`endif
            default: begin
            end
        endcase
    end

    // Reset blanks outputs combinationally so a write cannot land in the cycle rst rises.
    always_comb begin
        pc_write      = pc_write_d      & ~rst;
        pc_write_cond = pc_write_cond_d & ~rst;
        i_or_d        = i_or_d_d        & ~rst;
        mem_read      = mem_read_d      & ~rst;
        mem_write     = mem_write_d     & ~rst;
        ir_write      = ir_write_d      & ~rst;
        mem_to_reg    = mem_to_reg_d    & ~rst;
        pc_source     = rst ? 2'b00 : pc_source_d;
        alu_op        = rst ? 2'b00 : alu_op_d;
        alu_src_a     = alu_src_a_d     & ~rst;
        alu_src_b     = rst ? 2'b00 : alu_src_b_d;
        reg_write     = reg_write_d     & ~rst;
        reg_dst       = reg_dst_d       & ~rst;
        illegal_op    = illegal_op_d    & ~rst;
        state         = rst ? 4'd0 : state_q;
    end

endmodule

// File: doc/ee357_multicycle_control.md
# ee357_multicycle_control

Main control state machine for the multicycle MIPS datapath. Each cycle it drives the mux selects, ALU operation class and write enables for PC, IR, memory and register file. It sequences the shared ALU, memory port and shift-left-2 units through fetch, decode, execute, memory and write-back. Memory accesses wait on a `mem_ready` handshake, so the block also works with multi-cycle memories.

## Interface
Parameters:
- none; the encodings below are fixed.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26], sampled in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (beq).
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = MDR.
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target (IR[25:0]<<2 concatenated with PC[31:28]).
- alu_op  out  2  ALU class: 00 = add, 01 = subtract, 10 = funct-decoded.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate<<2.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  destination register: 0 = rt, 1 = rd.
- illegal_op  out  1  one-cycle flag for an unrecognised opcode.
- state  out  4  current state encoding, for debug.

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 are unreachable and return to FETCH on the next edge.
- Outputs are Moore-decoded from `state` (Mealy on `mem_ready` only where noted). Any output not listed for a state is 0.
- FETCH: mem_read=1, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE: alu_src_b=11, alu_op=00; this precomputes the branch target into ALUOut. Next state by opcode:
  - 100011 (lw) and 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXEC.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - 001000 (addi) → ADDIEX, only when the macro is defined.
  - Any other opcode → illegal_op=1 this cycle, then FETCH.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next state is MEMRD for lw, MEMWR for sw, using the opcode held stable in IR.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB: reg_write=1, reg_dst=1. Next: FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next: FETCH.
- JUMP: pc_write=1, pc_source=10. Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00. Next: ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.

## Timing
- Reset: a rising edge with rst=1 puts the FSM in FETCH.
  - While rst=1, every output is forced to 0, including ir_write, pc_write, mem_read and illegal_op.
  - The first cycle after rst falls is FETCH with mem_read=1.
- Reset in mid-instruction (for example in MEMWR or MEMWB) aborts the instruction. The combinational output force blocks writes in the same cycle rst rises.
- Cycles per instruction with mem_ready held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. Strobes stay asserted and write enables stay 0 during the wait.
- The FSM never waits on mem_ready in any other state. mem_ready is ignored outside FETCH, MEMRD and MEMWR.
- illegal_op is high for exactly one cycle, in DECODE.

## Configuration
- EE357_CTRL_ADDI_EN defined: opcode 001000 follows DECODE → ADDIEX → ADDIWB → FETCH.
- Not defined: 001000 raises illegal_op and returns to FETCH. States 10 and 11 then behave as unreachable codes.

## Test plan
- Reset with rst=1 for 2 cycles, then opcode=000000 and mem_ready=1:
  - All outputs are 0 during reset.
  - After reset, `state` reads 0, 1, 6, 7, 0.
  - reg_write=1 and reg_dst=1 only in state 7.
- lw (100011) with mem_ready low for 2 cycles in MEMRD:
  - state reads 0, 1, 2, 3, 3, 3, 4, 0.
  - mem_read=1 and i_or_d=1 throughout the three MEMRD cycles.
  - reg_write=1 and mem_to_reg=1 in state 4.
- sw (101011), beq (000100), j (000010) with mem_ready=1:
  - sw takes 4 cycles; mem_write=1 only in state 5.
  - beq takes 3 cycles; pc_write_cond=1, alu_op=01 and pc_source=01 only in state 8.
  - j takes 3 cycles; pc_write=1 and pc_source=10 in state 9.
- Opcode 111111: illegal_op=1 for exactly one cycle in state 1, then state 0. No write enable is asserted during the instruction except the FETCH ir_write and pc_write.
- addi (001000):
  - Macro defined: state reads 0, 1, 10, 11, 0; reg_write=1 and reg_dst=0 in state 11.
  - Macro undefined: illegal_op=1 in state 1, then state 0.
- Assert rst in MEMWR (lw/sw path, mem_ready=0): mem_write drops to 0 in the same cycle, and state=0 after the next edge.
